// File: rtl/imm_encoder.sv
// Packs a full-width immediate into the immediate fields of a RISC-V instruction word.
// Out-of-range immediates are rejected and counted; accepted words get sequential addresses.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  immsrc,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic        err_sticky,
    output logic [7:0]  err_count
);

    // Handshake: a beat transfers on an edge where valid && ready are both high;
    // valid never depends on ready, and the held word stays stable until it transfers.
    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b010;
    localparam logic [2:0] SRC_U = 3'b011;
    localparam logic [2:0] SRC_J = 3'b100;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_addr_q,  out_addr_d;
    logic [31:0] addr_cnt_q,  addr_cnt_d;
    logic        err_q,        err_d;
    logic        err_sticky_q, err_sticky_d;
    logic [7:0]  err_count_q,  err_count_d;

    logic [31:0] enc_instr;
    logic        legal;
    logic        accept;
    logic        load;
    logic        reject;

    // Legality means the dropped upper bits are pure sign extension and any
    // implicit zero LSBs really are zero, so the packed word decodes back to imm.
    always_comb begin
        enc_instr = base;
        legal     = 1'b0;
        case (immsrc)
            SRC_I: begin
                enc_instr[31:20] = imm[11:0];
                legal            = (imm[31:11] == {21{imm[11]}});
            end
            SRC_S: begin
                enc_instr[31:25] = imm[11:5];
                enc_instr[11:7]  = imm[4:0];
                legal            = (imm[31:11] == {21{imm[11]}});
            end
            SRC_B: begin
                enc_instr[31]    = imm[12];
                enc_instr[30:25] = imm[10:5];
                enc_instr[11:8]  = imm[4:1];
                enc_instr[7]     = imm[11];
                legal            = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            end
            SRC_U: begin
                enc_instr[31:12] = imm[31:12];
                legal            = (imm[11:0] == 12'h000);
            end
            SRC_J: begin
                enc_instr[31]    = imm[20];
                enc_instr[30:21] = imm[10:1];
                enc_instr[20]    = imm[11];
                enc_instr[19:12] = imm[19:12];
                legal            = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            end
            default: legal = 1'b0;
        endcase
    end

    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && legal;
    assign reject   = accept && !legal;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_addr_d   = out_addr_q;
        addr_cnt_d   = addr_cnt_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (clear) begin
            out_valid_d  = 1'b0;
            addr_cnt_d   = BASE_ADDR;
            err_sticky_d = 1'b0;
            err_count_d  = 8'h00;
        end else begin
            if (load) begin
                out_valid_d = 1'b1;
                out_instr_d = enc_instr;
                out_addr_d  = addr_cnt_q;
                addr_cnt_d  = addr_cnt_q + ADDR_STEP;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (reject) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0000_0000;
            out_addr_q   <= BASE_ADDR;
            addr_cnt_q   <= BASE_ADDR;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'h00;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_addr_q   <= out_addr_d;
            addr_cnt_q   <= addr_cnt_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_addr   = out_addr_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: hand-computed encodings, legality limits,
// backpressure, error saturation, clear and asynchronous reset.
module tb_imm_encoder;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immsrc;
    logic [31:0] imm;
    logic [31:0] base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic        err_sticky;
    logic [7:0]  err_count;

    int n_vec = 0;
    int n_err = 0;

    imm_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .immsrc     (immsrc),
        .imm        (imm),
        .base       (base),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err        (err),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] src, input logic [31:0] im, input logic [31:0] bs);
        in_valid = 1'b1;
        immsrc   = src;
        imm      = im;
        base     = bs;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        immsrc    = 3'b000;
        imm       = 32'h0;
        base      = 32'h0;
        out_ready = 1'b1;

        // Reset state
        #12;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_err_sticky", 32'(err_sticky), 32'd0);
        check_val("rst_err_count", 32'(err_count), 32'd0);
        check_val("rst_out_instr", out_instr, 32'h0);
        check_val("rst_out_addr", out_addr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check_val("post_rst_in_ready", 32'(in_ready), 32'd1);

        // I-type with imm = -1
        send(3'b000, 32'hFFFF_FFFF, 32'h0000_0013);
        check_val("i_valid", 32'(out_valid), 32'd1);
        check_val("i_instr", out_instr, 32'hFFF0_0013);
        check_val("i_addr", out_addr, 32'h0);
        step();
        check_val("drain_valid", 32'(out_valid), 32'd0);

        // B then U back to back, addresses 0 then 4
        do_clear();
        send(3'b010, 32'hFFFF_FFFC, 32'h0000_0063);
        check_val("b_instr", out_instr, 32'hFE00_0EE3);
        check_val("b_addr", out_addr, 32'h0);
        send(3'b011, 32'h1234_5000, 32'h0000_0037);
        check_val("u_valid", 32'(out_valid), 32'd1);
        check_val("u_instr", out_instr, 32'h1234_5037);
        check_val("u_addr", out_addr, 32'h4);
        step();

        // Two rejections: I imm=2048, B imm=3
        do_clear();
        send(3'b000, 32'h0000_0800, 32'h0000_0013);
        check_val("rej1_err", 32'(err), 32'd1);
        check_val("rej1_valid", 32'(out_valid), 32'd0);
        send(3'b010, 32'h0000_0003, 32'h0000_0063);
        check_val("rej2_err", 32'(err), 32'd1);
        check_val("rej2_valid", 32'(out_valid), 32'd0);
        check_val("rej2_count", 32'(err_count), 32'd2);
        check_val("rej2_sticky", 32'(err_sticky), 32'd1);
        step();
        check_val("err_pulse_end", 32'(err), 32'd0);
        // S-type imm=-1 after rejections keeps address 0
        send(3'b001, 32'hFFFF_FFFF, 32'h0000_0023);
        check_val("s_instr", out_instr, 32'hFE00_0FA3);
        check_val("s_addr", out_addr, 32'h0);
        check_val("s_err", 32'(err), 32'd0);
        // J-type imm=2 legal, at address 4
        send(3'b100, 32'h0000_0002, 32'h0000_006F);
        check_val("j_instr", out_instr, 32'h0020_006F);
        check_val("j_addr", out_addr, 32'h4);
        // Legality boundaries
        send(3'b000, 32'hFFFF_F800, 32'h0000_0013);
        check_val("i_min_ok", 32'(err), 32'd0);
        check_val("i_min_instr", out_instr, 32'h8000_0013);
        send(3'b010, 32'h0000_0FFE, 32'h0000_0063);
        check_val("b_max_ok", 32'(err), 32'd0);
        send(3'b010, 32'h0000_1000, 32'h0000_0063);
        check_val("b_over_err", 32'(err), 32'd1);
        send(3'b100, 32'h0010_0000, 32'h0000_006F);
        check_val("j_over_err", 32'(err), 32'd1);
        send(3'b100, 32'hFFF0_0000, 32'h0000_006F);
        check_val("j_min_ok", 32'(err), 32'd0);
        check_val("j_min_instr", out_instr, 32'h8000_006F);
        send(3'b011, 32'h0000_1001, 32'h0000_0037);
        check_val("u_low_err", 32'(err), 32'd1);
        send(3'b111, 32'h0000_0000, 32'h0000_0013);
        check_val("bad_src_err", 32'(err), 32'd1);
        check_val("err_count_6", 32'(err_count), 32'd6);
        step();

        // Backpressure: out_ready low for 3 cycles with a second request pending
        do_clear();
        out_ready = 1'b0;
        send(3'b000, 32'h0000_0005, 32'h0000_0013);
        check_val("bp_first_instr", out_instr, 32'h0050_0013);
        in_valid = 1'b1;
        immsrc   = 3'b000;
        imm      = 32'h0000_0006;
        base     = 32'h0000_0013;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
            step();
            check_val("bp_hold_instr", out_instr, 32'h0050_0013);
            check_val("bp_hold_addr", out_addr, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_in_ready_high", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_val("bp_second_valid", 32'(out_valid), 32'd1);
        check_val("bp_second_instr", out_instr, 32'h0060_0013);
        check_val("bp_second_addr", out_addr, 32'h4);
        step();
        check_val("bp_drained", 32'(out_valid), 32'd0);

        // 300 illegal requests saturate the counter
        in_valid = 1'b1;
        immsrc   = 3'b101;
        for (int i = 0; i < 300; i++) step();
        check_val("sat_count", 32'(err_count), 32'd255);
        check_val("sat_sticky", 32'(err_sticky), 32'd1);
        clear = 1'b1;
        #1;
        check_val("clear_in_ready", 32'(in_ready), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_val("clr_count", 32'(err_count), 32'd0);
        check_val("clr_sticky", 32'(err_sticky), 32'd0);
        check_val("clr_err", 32'(err), 32'd0);
        out_ready = 1'b0;
        send(3'b011, 32'hABCD_E000, 32'h0000_0037);
        check_val("clr_next_addr", out_addr, 32'h0);
        check_val("clr_next_instr", out_instr, 32'hABCD_E037);

        // Asynchronous reset while a word is held
        reset_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_instr", out_instr, 32'h0);
        check_val("arst_addr", out_addr, 32'h0);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        check_val("arst_idle_valid", 32'(out_valid), 32'd0);
        send(3'b000, 32'h0000_0001, 32'h0000_0013);
        check_val("arst_next_addr", out_addr, 32'h0);
        check_val("arst_next_instr", out_instr, 32'h0010_0013);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
